// File: rtl/ppu_ram_responder.sv
// Responder for the PPU nibble-serial RAM interface: cmd + 4 address nibbles in, 4 data nibbles out.
// Latency: first data nibble appears LATENCY cycles after the last address nibble (data_pins registered).
// No backpressure: the PPU owns the timing; addr_pins is only decoded in IDLE and ADDR.
module ppu_ram_responder #(
    parameter int RAM_PINS      = 4,
    parameter int MEM_ADDR_BITS = 10,
    parameter int LATENCY       = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [RAM_PINS-1:0]      addr_pins,
    output logic [RAM_PINS-1:0]      data_pins,
    input  logic                     host_we,
    input  logic [MEM_ADDR_BITS-1:0] host_addr,
    input  logic [15:0]              host_wdata,
    output logic                     busy,
    output logic                     err
);

    localparam int WW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WAIT = 2'd2,
        DATA = 2'd3
    } state_t;

    state_t                   state, state_next;
    logic [1:0]               nib_cnt, nib_next;
    logic [WW-1:0]            wait_cnt, wait_next;
    logic [11:0]              addr_lo;
    logic [15:0]              rd_word;
    logic [MEM_ADDR_BITS-1:0] word_addr;
    logic                     capture;
    logic                     bad_cmd;

    logic [15:0] mem [2**MEM_ADDR_BITS];

    // Final nibble arrives on the capture edge, so it is taken straight from the pins.
    assign word_addr = MEM_ADDR_BITS'({addr_pins, addr_lo});
    assign capture   = (state == ADDR) && (nib_cnt == 2'd3);
    assign bad_cmd   = (state == IDLE) && (addr_pins != 4'h0) && (addr_pins != 4'h1);
    assign busy      = (state != IDLE);

    // Host write port: independent of the FSM and of reset, so preloads survive a reset.
    always_ff @(posedge clk) begin
        if (host_we) begin
            mem[host_addr] <= host_wdata;
        end
    end

    // Read port: old data is returned if the host writes the same word on the capture edge.
    always_ff @(posedge clk) begin
        if (capture) begin
            rd_word <= mem[word_addr];
        end
    end

    // Collect the low three address nibbles, LSB nibble first.
    always_ff @(posedge clk) begin
        if (state == ADDR) begin
            addr_lo <= {addr_pins, addr_lo[11:4]};
        end
    end

    // State, counters, sticky error and the registered response nibble.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            nib_cnt   <= 2'd0;
            wait_cnt  <= '0;
            err       <= 1'b0;
            data_pins <= '0;
        end else begin
            state     <= state_next;
            nib_cnt   <= nib_next;
            wait_cnt  <= wait_next;
            err       <= err | bad_cmd;
            data_pins <= (state_next == DATA) ? rd_word[{nib_next, 2'b00} +: 4] : '0;
        end
    end

    // Frame sequencing: IDLE -> ADDR(4) -> WAIT(LATENCY) -> DATA(4) -> IDLE.
    always_comb begin
        state_next = state;
        nib_next   = nib_cnt;
        wait_next  = wait_cnt;
        case (state)
            IDLE: begin
                nib_next = 2'd0;
                if (addr_pins == 4'h1) begin
                    state_next = ADDR;
                end
            end
            ADDR: begin
                nib_next = nib_cnt + 2'd1;
                if (nib_cnt == 2'd3) begin
                    state_next = WAIT;
                    nib_next   = 2'd0;
                    wait_next  = '0;
                end
            end
            WAIT: begin
                wait_next = wait_cnt + WW'(1);
                if (wait_cnt == WW'(LATENCY - 1)) begin
                    state_next = DATA;
                    nib_next   = 2'd0;
                    wait_next  = '0;
                end
            end
            DATA: begin
                nib_next = nib_cnt + 2'd1;
                if (nib_cnt == 2'd3) begin
                    state_next = IDLE;
                    nib_next   = 2'd0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
